// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if: start/done operand and result bus for digit_serial_adder.
// DIGIT_SERIAL_ADDER_SUB_EN adds the Sub request bit and the V overflow flag.
interface digit_serial_adder_if #(parameter int WIDTH = 16);
    logic             start, Cin, busy, done, Cout;
    logic [WIDTH-1:0] A, B, Sum;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    logic             Sub, V;
    modport master(output start, A, B, Cin, Sub, input busy, done, Sum, Cout, V);
    modport slave(input start, A, B, Cin, Sub, output busy, done, Sum, Cout, V);
`else
    modport master(output start, A, B, Cin, input busy, done, Sum, Cout);
    modport slave(input start, A, B, Cin, output busy, done, Sum, Cout);
`endif
endinterface

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit adder processing DIGIT bits per clock with a start/done handshake.
// Optional subtract mode with overflow flag under DIGIT_SERIAL_ADDER_SUB_EN.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    digit_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, psum_nxt, sum_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] a_d, b_d, s;
    logic             carry, c, accept, last, cout_q, sub_in;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    logic v_q, v_nxt;
    assign sub_in = bus.Sub;
    // carry into the MSB is recovered from the top sum bit of the final digit
    assign v_nxt  = c ^ a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ s[DIGIT-1];
    assign bus.V  = v_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) v_q <= 1'b0;
        else if (state == RUN && last) v_q <= v_nxt;
`else
    assign sub_in = 1'b0;
`endif

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign last     = cnt == CW'(N - 1);
    assign a_d      = a_sh[DIGIT-1:0];
    assign b_d      = b_sh[DIGIT-1:0];
    assign {c, s}   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;

    // partial sum fills from the top so the last digit lands the result in place
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign psum_nxt = s;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] psum;
            assign psum_nxt = {s, psum};
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) psum <= '0;
                else if (state == RUN) psum <= psum_nxt[WIDTH-1:DIGIT];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = accept ? RUN :
                    (state == RUN && last) ? DONE :
                    (state == DONE) ? IDLE : state;
    end

    always_comb begin
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end

    // subtraction stores ~B and seeds the carry with 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.A;
            b_sh  <= sub_in ? ~bus.B : bus.B;
            carry <= sub_in ? 1'b1 : bus.Cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum_q  <= psum_nxt;
                cout_q <= c;
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed vectors against an arithmetic model of the digit-serial adder.
// Also checks DIGIT=1 and DIGIT=16 latencies; subtract tests need DIGIT_SERIAL_ADDER_SUB_EN.
module tb_digit_serial_adder;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    int          checks = 0, errors = 0;

    digit_serial_adder_if #(.WIDTH(16)) i4 ();
    digit_serial_adder_if #(.WIDTH(16)) i1 ();
    digit_serial_adder_if #(.WIDTH(16)) i16 ();

    assign i4.start = start;  assign i4.A = a;  assign i4.B = b;  assign i4.Cin = cin;
    assign i1.start = start;  assign i1.A = a;  assign i1.B = b;  assign i1.Cin = cin;
    assign i16.start = start; assign i16.A = a; assign i16.B = b; assign i16.Cin = cin;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    assign i4.Sub = sub; assign i1.Sub = sub; assign i16.Sub = sub;
`endif

    digit_serial_adder #(.WIDTH(16), .DIGIT(4))  dut (.clk(clk), .rst_n(rst_n), .bus(i4));
    digit_serial_adder #(.WIDTH(16), .DIGIT(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // returns {V, Cout, Sum}; V is the signed-overflow rule on the effective operands
    function automatic logic [17:0] calc(input logic [15:0] x, y, input logic ci, s);
        logic [15:0] yy;
        logic [16:0] r;
        logic        v;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'd0, s ? 1'b1 : ci};
        v  = (x[15] == yy[15]) && (r[15] != x[15]);
        return {v, r};
    endfunction

    // model: ph = -1 idle, 0..3 digits outstanding, 4 = done cycle
    int          ph = -1;
    logic [17:0] pend = '0;
    logic [15:0] exp_sum = '0;
    logic        exp_cout = 1'b0, exp_v = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = -1; exp_sum = '0; exp_cout = 1'b0; exp_v = 1'b0;
        end else if (ph == -1 || ph == 4) begin
            if (start) begin pend = calc(a, b, cin, sub); ph = 0; end
            else ph = -1;
        end else begin
            ph = ph + 1;
            if (ph == 4) {exp_v, exp_cout, exp_sum} = pend;
        end
    end

    always @(negedge clk) begin
        chk("m_busy", {31'd0, i4.busy}, {31'd0, ph >= 0 && ph < 4});
        chk("m_done", {31'd0, i4.done}, {31'd0, ph == 4});
        chk("m_sum", {16'd0, i4.Sum}, {16'd0, exp_sum});
        chk("m_cout", {31'd0, i4.Cout}, {31'd0, exp_cout});
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        chk("m_v", {31'd0, i4.V}, {31'd0, exp_v});
`endif
    end

    task automatic wait_done(input int lim, output int k);
        k = 0;
        while (k < lim) begin
            @(negedge clk);
            k++;
            if (i4.done) break;
        end
    endtask

    task automatic op(input string nm, input logic [15:0] x, y, input logic ci, s,
                      input logic [15:0] es, input logic ec, ev);
        int k;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = s; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(12, k);
        chk({nm, "_lat"}, k, 5);
        chk({nm, "_sum"}, {16'd0, i4.Sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, i4.Cout}, {31'd0, ec});
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        chk({nm, "_v"}, {31'd0, i4.V}, {31'd0, ev});
`else
        if (ev) chk({nm, "_v_unexpected"}, 32'd0, 32'd1);
`endif
    endtask

    task automatic lat_run(input string nm, input logic [15:0] x, y, input logic s,
                           input logic [15:0] es);
        int k1 = 0, k4 = 0, k16 = 0;
        logic [15:0] s1 = '0, s4 = '0, s16 = '0;
        repeat (20) @(posedge clk);
        #1; a = x; b = y; cin = 1'b0; sub = s; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (i1.done && k1 == 0) begin k1 = k; s1 = i1.Sum; end
            if (i4.done && k4 == 0) begin k4 = k; s4 = i4.Sum; end
            if (i16.done && k16 == 0) begin k16 = k; s16 = i16.Sum; end
        end
        chk({nm, "_lat1"}, k1, 17);
        chk({nm, "_lat4"}, k4, 5);
        chk({nm, "_lat16"}, k16, 2);
        chk({nm, "_sum1"}, {16'd0, s1}, {16'd0, es});
        chk({nm, "_sum16"}, {16'd0, s16}, {16'd0, es});
        chk({nm, "_sum4"}, {16'd0, s4}, {16'd0, es});
    endtask

    initial begin
        int k;
        int seen;
        #1 rst_n = 1'b0;
        #22 rst_n = 1'b1;
        op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        op("t2", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        // start held through RUN; operand changes after accept must not matter
        @(posedge clk); #1;
        a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        a = 16'h0001; b = 16'h0001;
        wait_done(8, k);
        chk("t3_lat", k, 3);
        chk("t3_sum", {16'd0, i4.Sum}, 32'h0);
        chk("t3_cout", {31'd0, i4.Cout}, 32'd1);
        wait_done(8, k);
        start = 1'b0;
        chk("t3_lat2", k, 5);
        chk("t3_sum2", {16'd0, i4.Sum}, 32'h2);
        // back-to-back: second op requested during the done cycle
        op("t4a", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        a = 16'h7FFF; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t4_hold", {16'd0, i4.Sum}, 32'h0100);
            chk("t4_nodone", {31'd0, i4.done}, 32'd0);
        end
        @(negedge clk);
        chk("t4_done", {31'd0, i4.done}, 32'd1);
        chk("t4_sum", {16'd0, i4.Sum}, 32'h8000);
        // asynchronous reset mid-operation
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, i4.busy}, 32'd0);
        chk("t5_done", {31'd0, i4.done}, 32'd0);
        chk("t5_sum", {16'd0, i4.Sum}, 32'h0);
        chk("t5_cout", {31'd0, i4.Cout}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (i4.done) seen++;
        end
        chk("t5_nodone", seen, 0);
        op("t5b", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        lat_run("tl", 16'h1234, 16'h4321, 1'b0, 16'h5555);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        op("t6a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op("t6b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        lat_run("t6l", 16'h8000, 16'h0001, 1'b1, 16'h7FFF);
        lat_run("t6m", 16'h0005, 16'h0007, 1'b1, 16'hFFFE);
`endif
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
